// File: rtl/spi_reg_master.sv
// SPI initiator for single-register read/write frames (CPOL=0), SCLK divided from clk.
// Host handshake: start is accepted in IDLE; busy covers the whole frame plus the CS idle gap.
module spi_reg_master #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] IDLE_LOAD  = 8'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t      state;
  logic [23:0] shreg;
  logic [7:0]  cnt;
  logic [4:0]  bit_cnt;
  logic        is_read;
  logic [7:0]  rx;
  logic [4:0]  last_bit;

  assign last_bit = is_read ? 5'd23 : 5'd15;

  // Frame sequencer: cnt times every phase, sclk toggles only inside XFER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= 24'h000000;
      cnt     <= 8'd0;
      bit_cnt <= 5'd0;
      is_read <= 1'b0;
      rx      <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_read <= rw;
            shreg   <= rw ? {1'b1, addr, 16'h0000} : {1'b0, addr, wdata, 8'h00};
            cs      <= 1'b0;
            busy    <= 1'b1;
            mosi    <= rw;
            cnt     <= SETUP_LOAD;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            sclk    <= 1'b1;
            mosi    <= shreg[23];
            shreg   <= {shreg[22:0], 1'b0};
            bit_cnt <= 5'd0;
            cnt     <= DIV_LOAD;
            state   <= XFER;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        XFER: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (sclk) begin
            // MISO is captured on the edge that lowers sclk; only the data byte matters.
            sclk <= 1'b0;
            if (bit_cnt >= 5'd16) begin
              rx <= {rx[6:0], miso};
            end
            cnt <= DIV_LOAD;
          end else if (bit_cnt == last_bit) begin
            mosi  <= 1'b0;
            cnt   <= HOLD_LOAD;
            state <= HOLD;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            sclk    <= 1'b1;
            mosi    <= shreg[23];
            shreg   <= {shreg[22:0], 1'b0};
            cnt     <= DIV_LOAD;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            cs    <= 1'b1;
            done  <= 1'b1;
            if (is_read) begin
              rdata <= rx;
            end
            cnt   <= IDLE_LOAD;
            state <= GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          sclk  <= 1'b0;
          cs    <= 1'b1;
          mosi  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: default-timing instance with a behavioural register
// slave, plus a minimum-timing instance (all parameters 1) for the fast read case.
module tb_spi_reg_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, rw, miso;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done, sclk, cs, mosi;
  logic [7:0] rdata;

  logic       f_start, f_rw, f_miso;
  logic [6:0] f_addr;
  logic [7:0] f_wdata;
  logic       f_busy, f_done, f_sclk, f_cs, f_mosi;
  logic [7:0] f_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_reg_master u_dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  spi_reg_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u_fast (
    .clk(clk), .rst(rst), .start(f_start), .rw(f_rw), .addr(f_addr), .wdata(f_wdata),
    .busy(f_busy), .done(f_done), .rdata(f_rdata), .sclk(f_sclk), .cs(f_cs), .mosi(f_mosi),
    .miso(f_miso)
  );

  // Slave model and counters for the default instance, all sampled on the falling clk edge.
  logic [7:0]  sreg [128];
  logic [31:0] s_sh, cap;
  logic [7:0]  s_rd;
  int          s_n, cap_n;
  int          cs_low_tot, busy_tot, done_tot, rise_tot, cs_fall_tot;
  logic        cs_p, sclk_p;
  logic        force_en;
  logic [7:0]  force_byte;

  initial begin
    for (int i = 0; i < 128; i++) sreg[i] = 8'h00;
    miso = 1'b0; s_sh = 32'h0; cap = 32'h0; s_rd = 8'h00; s_n = 0; cap_n = 0;
    cs_low_tot = 0; busy_tot = 0; done_tot = 0; rise_tot = 0; cs_fall_tot = 0;
    cs_p = 1'b1; sclk_p = 1'b0;
    forever begin
      @(negedge clk);
      if (cs === 1'b0) cs_low_tot++;
      if (busy === 1'b1) busy_tot++;
      if (done === 1'b1) done_tot++;
      if (cs_p && !cs) begin
        s_n = 0; s_sh = 32'h0; cs_fall_tot++;
      end
      if (!cs_p && cs) begin
        cap = s_sh; cap_n = s_n;
        if (s_n == 16 && s_sh[15] == 1'b0) sreg[s_sh[14:8]] = s_sh[7:0];
      end
      if (!sclk_p && sclk) begin
        rise_tot++;
        if (!cs && s_n >= 16) miso = s_rd[23-s_n];
      end
      if (sclk_p && !sclk && !cs) begin
        s_sh = {s_sh[30:0], mosi};
        s_n++;
        if (s_n == 8) s_rd = force_en ? force_byte : sreg[s_sh[6:0]];
      end
      cs_p = cs; sclk_p = sclk;
    end
  end

  // Fast-instance observer: MISO returns 8'h5A, sclk rises must be exactly 2 clocks apart.
  logic [31:0] f_sh;
  logic [7:0]  f_byte;
  int          f_n, f_rises, f_hi, f_cs_low, f_pbad, f_last, cyc;
  logic        f_cs_p, f_sclk_p;

  initial begin
    f_miso = 1'b0; f_sh = 32'h0; f_byte = 8'h5A; f_n = 0; f_rises = 0; f_hi = 0;
    f_cs_low = 0; f_pbad = 0; f_last = -1; cyc = 0; f_cs_p = 1'b1; f_sclk_p = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (f_cs === 1'b0) f_cs_low++;
      if (f_sclk === 1'b1) f_hi++;
      if (f_cs_p && !f_cs) begin
        f_n = 0; f_sh = 32'h0; f_last = -1;
      end
      if (!f_sclk_p && f_sclk) begin
        f_rises++;
        if (f_last >= 0 && (cyc - f_last) != 2) f_pbad++;
        f_last = cyc;
        if (!f_cs && f_n >= 16) f_miso = f_byte[23-f_n];
      end
      if (f_sclk_p && !f_sclk && !f_cs) begin
        f_sh = {f_sh[30:0], f_mosi};
        f_n++;
      end
      f_cs_p = f_cs; f_sclk_p = f_sclk;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; rw = r; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  int b_cs, b_busy, b_done, b_rise, b_fall;

  task automatic snap();
    b_cs = cs_low_tot; b_busy = busy_tot; b_done = done_tot; b_rise = rise_tot;
    b_fall = cs_fall_tot;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
    f_start = 1'b0; f_rw = 1'b0; f_addr = 7'h00; f_wdata = 8'h00;
    force_en = 1'b0; force_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs", {31'd0, cs}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x05 <- 0xA5
    snap();
    issue(1'b0, 7'h05, 8'hA5);
    wait_idle("wr_timeout");
    chk("wr_mosi", {16'd0, cap[15:0]}, 32'h05A5);
    chk("wr_bits", cap_n, 32'd16);
    chk("wr_pulses", rise_tot - b_rise, 32'd16);
    chk("wr_cs_low", cs_low_tot - b_cs, 32'd70);
    chk("wr_busy", busy_tot - b_busy, 32'd72);
    chk("wr_done", done_tot - b_done, 32'd1);
    chk("wr_reg5", {24'd0, sreg[5]}, 32'hA5);

    // Read back 0x05
    snap();
    issue(1'b1, 7'h05, 8'h00);
    wait_idle("rd_timeout");
    chk("rd_mosi", {8'd0, cap[23:0]}, 32'h850000);
    chk("rd_pulses", rise_tot - b_rise, 32'd24);
    chk("rd_cs_low", cs_low_tot - b_cs, 32'd102);
    chk("rd_busy", busy_tot - b_busy, 32'd104);
    chk("rd_done", done_tot - b_done, 32'd1);
    chk("rd_rdata", {24'd0, rdata}, 32'hA5);

    // Forced MISO bytes, rdata held between frames
    force_en = 1'b1; force_byte = 8'h3C;
    issue(1'b1, 7'h20, 8'h00);
    wait_idle("rd3c_timeout");
    chk("rd_3c", {24'd0, rdata}, 32'h3C);
    force_byte = 8'hC3;
    repeat (20) @(negedge clk);
    chk("rd_hold", {24'd0, rdata}, 32'h3C);
    issue(1'b1, 7'h21, 8'h00);
    wait_idle("rdc3_timeout");
    chk("rd_c3", {24'd0, rdata}, 32'hC3);
    force_en = 1'b0;

    // start held high through a write: one frame only
    snap();
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'h06; wdata = 8'h11;
    @(negedge clk);
    wdata = 8'h22;
    repeat (60) @(negedge clk);
    start = 1'b0;
    wait_idle("hold_timeout");
    chk("hold_frames", cs_fall_tot - b_fall, 32'd1);
    chk("hold_done", done_tot - b_done, 32'd1);
    chk("hold_reg6", {24'd0, sreg[6]}, 32'h11);
    chk("hold_rdata", {24'd0, rdata}, 32'hC3);

    // Back-to-back: start in first IDLE clock after busy falls
    snap();
    issue(1'b0, 7'h08, 8'h81);
    wait_idle("b2b_timeout1");
    chk("b2b_cs_idle", {31'd0, cs}, 32'd1);
    start = 1'b1; rw = 1'b0; addr = 7'h09; wdata = 8'h92;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_cs_fall", {31'd0, cs}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle("b2b_timeout2");
    repeat (2) @(negedge clk);
    chk("b2b_reg8", {24'd0, sreg[8]}, 32'h81);
    chk("b2b_reg9", {24'd0, sreg[9]}, 32'h92);
    chk("b2b_frames", cs_fall_tot - b_fall, 32'd2);

    // Reset in the middle of a write
    snap();
    issue(1'b0, 7'h07, 8'h77);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (s_n == 10 && cs === 1'b0) begin
          hit = 1'b1;
          break;
        end
      end
      chk("abort_reach", {31'd0, hit}, 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("abort_cs", {31'd0, cs}, 32'd1);
    chk("abort_sclk", {31'd0, sclk}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", {24'd0, rdata}, 32'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_done", done_tot - b_done, 32'd0);
    chk("abort_reg7", {24'd0, sreg[7]}, 32'h00);
    snap();
    issue(1'b0, 7'h07, 8'h77);
    wait_idle("post_timeout");
    repeat (2) @(negedge clk);
    chk("post_reg7", {24'd0, sreg[7]}, 32'h77);
    chk("post_done", done_tot - b_done, 32'd1);

    // Minimum-timing read on the fast instance
    begin
      int c0, r0, h0;
      logic ok;
      c0 = f_cs_low; r0 = f_rises; h0 = f_hi;
      @(negedge clk);
      f_start = 1'b1; f_rw = 1'b1; f_addr = 7'h12; f_wdata = 8'h00;
      @(negedge clk);
      f_start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (f_busy === 1'b0) begin
          ok = 1'b1;
          break;
        end
      end
      chk("fast_timeout", {31'd0, ok}, 32'd1);
      chk("fast_cs_low", f_cs_low - c0, 32'd50);
      chk("fast_pulses", f_rises - r0, 32'd24);
      chk("fast_hi", f_hi - h0, 32'd24);
      chk("fast_period", f_pbad, 32'd0);
      chk("fast_mosi", {8'd0, f_sh[23:0]}, 32'h920000);
      chk("fast_rdata", {24'd0, f_rdata}, 32'h5A);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI initiator that issues single-register read and write transactions to the SPI register-access slave (CPOL=0, slave samples MOSI on SCLK falling edge). It sits in the system clock domain and derives SCLK by division. A host-side start/busy/done handshake sequences complete chip-select frames. It is the bench driver for the slave today and the on-chip bridge for future dual-die configurations.

## Interface
- CLK_DIV, 2: system clocks per SCLK half-period (1..255)
- CS_SETUP, 2: clocks CS low with SCLK low before first SCLK rise (1..255)
- CS_HOLD, 4: clocks after last SCLK fall before CS rises (1..255)
- CS_IDLE, 2: clocks CS high after a frame before busy drops (1..255)
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only while busy=0
- rw  in  1  1=read, 0=write; latched on accept
- addr  in  7  register address; latched on accept
- wdata  in  8  write data; latched on accept
- busy  out  1  high from accept until end of CS_IDLE gap
- done  out  1  one-clock pulse when frame ends
- rdata  out  8  last read byte; held until next read completes
- sclk  out  1  SPI clock, idle low
- cs  out  1  chip select, active low, idle high
- mosi  out  1  SPI data out, MSB first
- miso  in  1  SPI data in

## Operation
- Frame: write = 16 bits {0, addr, wdata}; read = 24 bits {1, addr, 8'h00, 8'h00}; read data returned on MISO during bits 16..23, MSB first.
- States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
- IDLE: cs=1, sclk=0, mosi=0. start=1 latches rw/addr/wdata into 24-bit shift register, goes to SETUP.
- SETUP: cs=0, sclk=0, mosi=frame bit 23 (rw); CS_SETUP clocks.
- XFER: per bit n (0..len-1): sclk high CLK_DIV clocks, then low CLK_DIV clocks. mosi updates on the clk edge that raises sclk, holding frame bit (23-n) for the whole bit period.
- MISO: sampled on the clk edge that drives sclk 1->0 (direct, no synchroniser; sclk derives from clk). Bits 16..23 shift into a receive register, MSB first.
- HOLD: cs=0, sclk=0, mosi=0 for CS_HOLD clocks; gives the slave's write enable time to be captured.
- GAP: cs=1; done pulses on the first GAP clock; on reads, rdata loads the receive register in that same cycle. Stays CS_IDLE clocks, then IDLE, busy=0.
- start while busy=1: ignored. No queuing.
- start asserted in the first IDLE clock after busy drops: accepted.
- Counter widths: divider and phase counters 8 bits; bit counter 5 bits; no wrap within legal parameters.

## Timing
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=8'h00, state IDLE.
- Reset mid-frame: outputs return to reset values asynchronously. CS rising aborts the slave transaction. No done pulse. rdata is cleared.
- Accept edge E0: cs and busy high->low/low->high at E0.
- First sclk rise at E0+CS_SETUP. Last sclk fall at E0+CS_SETUP+2*CLK_DIV*len.
- cs rise and done at E0+CS_SETUP+2*CLK_DIV*len+CS_HOLD. busy falls CS_IDLE clocks later.
- Defaults: write cs low 70 clocks; read cs low 102 clocks; busy high 72 / 104 clocks.
- sclk duty 50%. Minimum SCLK period 2 clocks (CLK_DIV=1).

## Test plan
- Write addr 7'h05 data 8'hA5: MOSI captured on sclk falls = 16'h05A5. Exactly 16 sclk pulses. Slave register 5 = 8'hA5. Single done pulse. cs low 70 clocks.
- Read addr 7'h05 after that write: 24 sclk pulses. MOSI = 24'h850000. rdata=8'hA5 at done. busy low 104 clocks after accept.
- Read with miso model returning 8'h3C then 8'hC3: rdata 8'h3C after first done, 8'hC3 after second. rdata stable between frames.
- start pulsed every clock during a write: exactly one frame, one done. Back-to-back start at busy fall: new cs fall on that accept edge.
- rst asserted at bit 10 of a write: cs=1, sclk=0 immediately. No done. Slave register unchanged. Next write after reset completes normally.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_IDLE=1 read: sclk period 2 clocks. Correct rdata. cs low 1+48+1=50 clocks.
